// File: rtl/inst_mem_fetch.sv
// Synchronous instruction memory: valid/ready fetch, 1-cycle read, 2-entry response buffer.
// Optional macro INST_MEM_LOAD_EN enables the word-write load port; otherwise a fixed ROM image.
module inst_mem_fetch #(
  parameter int INST_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 17,
  parameter int BYTE_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INST_W-1:0]     rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [INST_W-1:0]     ld_data
);

  localparam int IDX_HI = DEPTH_LOG2 + BYTE_SHIFT;

  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_misalign;
  logic                    w_oor;
  logic                    w_err;
  logic [1:0]              w_occ;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;

  logic                    r_inflight;
  logic                    r_inf_err;
  logic [INST_W-1:0]       r_rdata;
  logic [1:0][INST_W-1:0]  r_buf_inst;
  logic [1:0]              r_buf_err;
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  assign w_idx = req_addr[IDX_HI-1:BYTE_SHIFT];

  generate
    if (BYTE_SHIFT > 0) begin : g_align
      assign w_misalign = |req_addr[BYTE_SHIFT-1:0];
    end else begin : g_noalign
      assign w_misalign = 1'b0;
    end
    if (IDX_HI < ADDR_W) begin : g_range
      assign w_oor = |req_addr[ADDR_W-1:IDX_HI];
    end else begin : g_norange
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_err = w_misalign | w_oor;

  // Occupancy counts the in-flight read so a stalled consumer can never overflow the buffer.
  assign w_occ     = r_count + {1'b0, r_inflight};
  assign req_ready = rst & ce & (w_occ < 2'd2);
  assign w_accept  = req_valid & req_ready;
  assign w_push    = r_inflight;
  assign w_pop     = rsp_valid & rsp_ready;

  assign rsp_valid = (r_count != 2'd0);
  assign rsp_inst  = r_buf_inst[r_rd_ptr];
  assign rsp_err   = r_buf_err[r_rd_ptr];

`ifdef INST_MEM_LOAD_EN
  logic [INST_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_idx] <= ld_data;
  end

  // Same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_accept) r_rdata <= r_mem[w_idx];
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{ld_en, ld_idx, ld_data};

  function automatic logic [INST_W-1:0] rom_word(input logic [DEPTH_LOG2-1:0] idx);
    logic [INST_W-1:0] w;
    w = '0;
    case (idx)
      DEPTH_LOG2'(0): w = INST_W'(64'h2010880000000400);
      DEPTH_LOG2'(1): w = INST_W'(64'h2010840000000800);
      DEPTH_LOG2'(2): w = INST_W'(64'h2011900000072000);
      DEPTH_LOG2'(3): w = INST_W'(64'h20118c0000040800);
      default:        w = '0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (w_accept) r_rdata <= rom_word(w_idx);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
      r_inf_err  <= 1'b0;
      r_buf_inst <= '0;
      r_buf_err  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (!ce) begin
      // Flush: drop buffered responses and the in-flight read.
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) r_inf_err <= w_err;
      if (w_push) begin
        r_buf_inst[r_wr_ptr] <= r_inf_err ? '0 : r_rdata;
        r_buf_err[r_wr_ptr]  <= r_inf_err;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Self-checking bench for inst_mem_fetch: directed vector table, async reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_inst_mem_fetch;

  localparam logic [63:0] W0 = 64'h2010880000000400;
  localparam logic [63:0] W1 = 64'h2010840000000800;
  localparam logic [63:0] W2 = 64'h2011900000072000;
  localparam logic [63:0] W3 = 64'h20118c0000040800;
`ifdef INST_MEM_LOAD_EN
  localparam logic [63:0] DEAD_EXP = 64'hDEAD;
`else
  localparam logic [63:0] DEAD_EXP = W2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_inst;
  logic        rsp_err;
  logic        ld_en = 1'b0;
  logic [16:0] ld_idx = '0;
  logic [63:0] ld_data = '0;

  inst_mem_fetch dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [31:0] a, input logic r,
                       input logic l, input logic [16:0] i, input logic [63:0] d);
    ce = c; req_valid = v; req_addr = a; rsp_ready = r;
    ld_en = l; ld_idx = i; ld_data = d;
  endtask

  typedef struct {
    logic        ce, vld;
    logic [31:0] addr;
    logic        rdy, ld;
    logic [16:0] idx;
    logic [63:0] data;
    logic        e_rr, e_rv;
    logic [63:0] e_inst;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic v, input logic [31:0] a, input logic r,
                              input logic l, input logic [16:0] i, input logic [63:0] d,
                              input logic err_rr, input logic err_rv, input logic [63:0] ei,
                              input logic ee);
    vec_t x;
    x.ce = c; x.vld = v; x.addr = a; x.rdy = r; x.ld = l; x.idx = i; x.data = d;
    x.e_rr = err_rr; x.e_rv = err_rv; x.e_inst = ei; x.e_err = ee;
    return x;
  endfunction

  // Reference model: outstanding responses in order, each visible from a given edge count.
  typedef struct {
    logic [63:0] inst;
    logic        err;
    int          vis;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  logic [63:0] mdl [int];

  task automatic rstep(input logic c, input logic v, input logic [31:0] a, input logic r,
                       input logic l, input logic [16:0] i, input logic [63:0] d);
    logic e_rr, e_rv, acc, pop;
    ent_t e;
    e = '{inst: 64'h0, err: 1'b0, vis: 0};
    drive(c, v, a, r, l, i, d);
    #1;
    e_rr = c && (q.size() < 2);
    e_rv = (q.size() > 0) && (q[0].vis <= cyc);
    chk("rnd.req_ready", {63'h0, req_ready}, {63'h0, e_rr});
    chk("rnd.rsp_valid", {63'h0, rsp_valid}, {63'h0, e_rv});
    if (e_rv) begin
      chk("rnd.rsp_inst", rsp_inst, q[0].inst);
      chk("rnd.rsp_err", {63'h0, rsp_err}, {63'h0, q[0].err});
    end
    acc = v && e_rr;
    pop = e_rv && r;
    if (acc) begin
      e.err  = (a[2:0] != 3'd0) || (a[31:20] != 12'd0);
      e.inst = e.err ? 64'h0 : (mdl.exists(int'(a[19:3])) ? mdl[int'(a[19:3])] : 64'h0);
    end
    @(posedge clk);
    cyc++;
    if (!c) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.vis = cyc + 1;
        q.push_back(e);
      end
    end
`ifdef INST_MEM_LOAD_EN
    if (l) mdl[int'(i)] = d;
`endif
    #1;
  endtask

  initial begin
    // Loads, streaming, backpressure, errors, collision, flush
    for (int i = 0; i < 4; i++) begin
      logic [63:0] w;
      w = (i == 0) ? W0 : (i == 1) ? W1 : (i == 2) ? W2 : W3;
      tbl.push_back(mk(1, 0, 0, 1, 1, 17'(i), w, 1, 0, 0, 0));
    end
    tbl.push_back(mk(1, 1, 32'h00, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h08, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 0, 0, 0, 1, 1, W1, 0));
    tbl.push_back(mk(1, 1, 32'h18, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 0, 1, W2, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 1, W3, 0));
    tbl.push_back(mk(1, 1, 32'h00, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h08, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 0, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 0, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 0, 0, 0, 1, 1, W1, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 1, W2, 0));
    tbl.push_back(mk(1, 1, 32'h08, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h04, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h04, 1, 0, 0, 0, 0, 1, W1, 0));
    tbl.push_back(mk(1, 1, 32'h00100000, 1, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 32'h18, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 1, W3, 0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 1, 2, 64'hDEAD, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 0, 1, W2, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 1, DEAD_EXP, 0));
    tbl.push_back(mk(1, 0, 0,      1, 1, 2, W2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h00, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h08, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      0, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(1, 1, 32'h18, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 1, W3, 0));
    tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0, 1, 0, 0, 0));

    // Reset held for 3 cycles with ce=1
    drive(1, 0, 0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst.rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst.rsp_inst", rsp_inst, 64'h0);
    chk("rst.rsp_err", {63'h0, rsp_err}, 64'h0);
    rst = 1'b1;
    #1;
    chk("rel.req_ready", {63'h0, req_ready}, 64'h1);
    chk("rel.rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rel.rsp_inst", rsp_inst, 64'h0);
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].ce, tbl[k].vld, tbl[k].addr, tbl[k].rdy, tbl[k].ld, tbl[k].idx, tbl[k].data);
      #1;
      chk($sformatf("vec%0d.req_ready", k), {63'h0, req_ready}, {63'h0, tbl[k].e_rr});
      chk($sformatf("vec%0d.rsp_valid", k), {63'h0, rsp_valid}, {63'h0, tbl[k].e_rv});
      if (tbl[k].e_rv) begin
        chk($sformatf("vec%0d.rsp_inst", k), rsp_inst, tbl[k].e_inst);
        chk($sformatf("vec%0d.rsp_err", k), {63'h0, rsp_err}, {63'h0, tbl[k].e_err});
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with a buffered response clears outputs without a clock edge
    drive(1, 1, 32'h08, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("arst.pre_valid", {63'h0, rsp_valid}, 64'h1);
    chk("arst.pre_inst", rsp_inst, W1);
    rst = 1'b0;
    #1;
    chk("arst.rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("arst.req_ready", {63'h0, req_ready}, 64'h0);
    chk("arst.rsp_inst", rsp_inst, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.rel_ready", {63'h0, req_ready}, 64'h1);
    @(posedge clk);
    #1;

    // Randomized traffic against the model
`ifndef INST_MEM_LOAD_EN
    mdl[0] = W0; mdl[1] = W1; mdl[2] = W2; mdl[3] = W3;
`endif
    for (int i = 0; i < 8; i++)
      rstep(1, 0, 0, 1, 1, 17'(i), {$urandom, $urandom});
    for (int n = 0; n < 600; n++) begin
      logic        c, v, r, l;
      logic [31:0] a;
      logic [16:0] li;
      int          sel;
      c   = ($urandom_range(0, 19) != 0);
      v   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 9) < 6);
      l   = ($urandom_range(0, 4) == 0);
      li  = 17'($urandom_range(0, 7));
      a   = 32'($urandom_range(0, 7)) << 3;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = a | 32'($urandom_range(1, 7));
      else if (sel == 1) a = a | (32'($urandom_range(1, 4095)) << 20);
      rstep(c, v, a, r, l, li, {$urandom, $urandom});
    end
    for (int n = 0; n < 4; n++)
      rstep(1, 0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
